// File: rtl/tmds_encoder_multi.sv
// CHANNELS-lane TMDS encoder: video (DVI balancing), control, TERC4 data island
// and guard band, two-stage pipeline, independent running disparity per lane.
module tmds_encoder_multi #(
    parameter int CHANNELS = 3,
    parameter int DISP_W   = 5
) (
    input  logic                   pixclk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [8*CHANNELS-1:0]  vd,
    input  logic [2*CHANNELS-1:0]  cd,
    input  logic [4*CHANNELS-1:0]  aux,
    output logic [10*CHANNELS-1:0] tmds,
    output logic [1:0]             mode_out
);

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'b00,
        MODE_VIDEO = 2'b01,
        MODE_TERC4 = 2'b10,
        MODE_GUARD = 2'b11
    } mode_e;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] a);
        case (a)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    mode_e s1_mode;

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_mode  <= MODE_CTRL;
            mode_out <= 2'b00;
        end else begin
            s1_mode  <= mode_e'(mode);
            mode_out <= s1_mode;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        localparam logic signed [DISP_W-1:0] ZERO  = '0;
        localparam logic signed [DISP_W-1:0] TWO   = DISP_W'(2);
        localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(8);
        localparam logic [9:0] GUARD_SYM = (k % 3 == 1) ? GUARD_B : GUARD_A;

        logic [7:0] d;
        logic [3:0] n1_d;
        logic       use_xnor;
        logic       chain;
        logic [8:0] qm_next;
        logic [3:0] ones_next;

        logic [8:0] s1_qm;
        logic [3:0] s1_ones;
        logic [1:0] s1_cd;
        logic [3:0] s1_aux;

        logic signed [DISP_W-1:0] cnt, cnt_next, n1s, n0s, diff;
        logic [9:0] sym, sym_next;

        assign d = vd[8*k +: 8];

        always_comb begin
            n1_d = '0;
            for (int unsigned i = 0; i < 8; i++) n1_d = n1_d + 4'(d[i]);
            use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
            chain    = d[0];
            qm_next  = '0;
            qm_next[0] = d[0];
            for (int unsigned i = 1; i < 8; i++) begin
                chain      = use_xnor ? ~(chain ^ d[i]) : (chain ^ d[i]);
                qm_next[i] = chain;
            end
            qm_next[8] = ~use_xnor;
            ones_next  = '0;
            for (int unsigned i = 0; i < 8; i++) ones_next = ones_next + 4'(qm_next[i]);
        end

        // Any non-video symbol resets this lane's disparity to zero.
        always_comb begin
            n1s      = DISP_W'(s1_ones);
            n0s      = EIGHT - n1s;
            diff     = n1s - n0s;
            sym_next = CTRL_00;
            cnt_next = ZERO;
            case (s1_mode)
                MODE_VIDEO: begin
                    if (cnt == ZERO || n1s == n0s) begin
                        sym_next = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
                        cnt_next = s1_qm[8] ? cnt + diff : cnt - diff;
                    end else if ((cnt > ZERO && n1s > n0s) || (cnt < ZERO && n0s > n1s)) begin
                        sym_next = {1'b1, s1_qm[8], ~s1_qm[7:0]};
                        cnt_next = cnt - diff + (s1_qm[8] ? TWO : ZERO);
                    end else begin
                        sym_next = {1'b0, s1_qm[8], s1_qm[7:0]};
                        cnt_next = cnt + diff - (s1_qm[8] ? ZERO : TWO);
                    end
                end
                MODE_CTRL:  sym_next = ctrl_sym(s1_cd);
                MODE_TERC4: sym_next = terc4_sym(s1_aux);
                MODE_GUARD: sym_next = GUARD_SYM;
                default:    sym_next = CTRL_00;
            endcase
        end

        always_ff @(posedge pixclk or negedge rst_n) begin
            if (!rst_n) begin
                s1_qm   <= '0;
                s1_ones <= '0;
                s1_cd   <= '0;
                s1_aux  <= '0;
                cnt     <= '0;
                sym     <= CTRL_00;
            end else begin
                s1_qm   <= qm_next;
                s1_ones <= ones_next;
                s1_cd   <= cd[2*k +: 2];
                s1_aux  <= aux[4*k +: 4];
                cnt     <= cnt_next;
                sym     <= sym_next;
            end
        end

        assign tmds[10*k +: 10] = sym;
    end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Self-checking bench for tmds_encoder_multi (4 lanes) against a behavioural
// model that tracks disparity as the ones/zeros balance of emitted symbols.
module tb_tmds_encoder_multi;

    localparam int CH = 4;
    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] CTRL [4] = '{10'b1101010100, 10'b0010101011,
                                        10'b0101010100, 10'b1010101011};
    localparam logic [9:0] TERC [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    logic              pixclk = 1'b0;
    logic              rst_n  = 1'b0;
    logic [1:0]        mode   = '0;
    logic [8*CH-1:0]   vd     = '0;
    logic [2*CH-1:0]   cd     = '0;
    logic [4*CH-1:0]   aux    = '0;
    logic [10*CH-1:0]  tmds;
    logic [1:0]        mode_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10*CH-1:0] sym;
        logic [1:0]       md;
    } exp_t;

    exp_t             expq[$];
    logic [10*CH-1:0] obs[$];
    int               mcnt[CH];

    tmds_encoder_multi #(.CHANNELS(CH), .DISP_W(5)) dut (
        .pixclk  (pixclk),
        .rst_n   (rst_n),
        .mode    (mode),
        .vd      (vd),
        .cd      (cd),
        .aux     (aux),
        .tmds    (tmds),
        .mode_out(mode_out)
    );

    always #5 pixclk = ~pixclk;

    task automatic model_lane(input logic [1:0] m, input int k, input logic [7:0] d,
                              input logic [1:0] c, input logic [3:0] a,
                              output logic [9:0] s);
        int n1;
        int qn1;
        logic xn;
        logic [8:0] q;
        if (m == 2'b01) begin
            n1 = $countones(d);
            xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            q[0] = d[0];
            for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
            q[8] = ~xn;
            qn1 = $countones(q[7:0]);
            if (mcnt[k] == 0 || qn1 == 4)
                s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            else if ((mcnt[k] > 0 && qn1 > 4) || (mcnt[k] < 0 && qn1 < 4))
                s = {1'b1, q[8], ~q[7:0]};
            else
                s = {1'b0, q[8], q[7:0]};
            mcnt[k] += 2 * $countones(s) - 10;
        end else begin
            mcnt[k] = 0;
            if (m == 2'b00)      s = CTRL[c];
            else if (m == 2'b10) s = TERC[a];
            else                 s = (k % 3 == 1) ? 10'b0100110011 : 10'b1011001100;
        end
    endtask

    task automatic restart_model;
        exp_t e;
        expq.delete();
        e.sym = {CH{C00}};
        e.md  = 2'b00;
        expq.push_back(e);
        expq.push_back(e);
        for (int k = 0; k < CH; k++) mcnt[k] = 0;
    endtask

    // Compare the symbol from two drives ago, then drive the next input.
    task automatic step(input logic [1:0] m, input logic [8*CH-1:0] v,
                        input logic [2*CH-1:0] c, input logic [4*CH-1:0] a);
        exp_t e;
        logic [9:0] s;
        @(negedge pixclk);
        e = expq.pop_front();
        checks++;
        if (tmds !== e.sym) begin
            errors++;
            $display("FAIL stream_tmds t=%0t got %h want %h", $time, tmds, e.sym);
        end
        checks++;
        if (mode_out !== e.md) begin
            errors++;
            $display("FAIL stream_mode t=%0t got %b want %b", $time, mode_out, e.md);
        end
        obs.push_back(tmds);
        mode = m; vd = v; cd = c; aux = a;
        for (int k = 0; k < CH; k++) begin
            model_lane(m, k, v[8*k +: 8], c[2*k +: 2], a[4*k +: 4], s);
            e.sym[10*k +: 10] = s;
        end
        e.md = m;
        expq.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mode  = 2'b01;
        vd    = $urandom;
        repeat (3) @(posedge pixclk);
        @(negedge pixclk);
        checks++;
        if (tmds !== {CH{C00}}) begin
            errors++;
            $display("FAIL reset_tmds got %h want %h", tmds, {CH{C00}});
        end
        checks++;
        if (mode_out !== 2'b00) begin
            errors++;
            $display("FAIL reset_mode got %b want 00", mode_out);
        end
        mode = 2'b00; vd = '0; cd = '0; aux = '0;
        rst_n = 1'b1;
        restart_model();
    endtask

    task automatic test_control;
        logic [2*CH-1:0] c;
        obs.delete();
        for (int i = 0; i < 6; i++) begin
            c = 2*CH'($urandom);
            c[1:0] = 2'b01;
            step(2'b00, $urandom, c, $urandom);
        end
        for (int i = 2; i < 6; i++) begin
            checks++;
            if (obs[i][9:0] !== 10'b0010101011) begin
                errors++;
                $display("FAIL ctrl_lane0 idx=%0d got %b want 0010101011", i, obs[i][9:0]);
            end
        end
    endtask

    task automatic test_video_zero;
        logic [9:0] want [3];
        logic [8*CH-1:0] v;
        want = '{10'b0100000000, 10'b1111111111, 10'b0100000000};
        step(2'b00, $urandom, '0, $urandom);
        obs.delete();
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            v[7:0] = 8'h00;
            step(2'b01, v, $urandom, $urandom);
        end
        step(2'b00, $urandom, $urandom, $urandom);
        step(2'b00, $urandom, $urandom, $urandom);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[2+i][9:0] !== want[i]) begin
                errors++;
                $display("FAIL video_00 sym=%0d got %b want %b", i, obs[2+i][9:0], want[i]);
            end
        end
    endtask

    task automatic test_video_ff;
        logic [8*CH-1:0] v;
        step(2'b00, $urandom, '0, $urandom);
        obs.delete();
        v = $urandom;
        v[7:0] = 8'hFF;
        step(2'b01, v, $urandom, $urandom);
        step(2'b00, $urandom, $urandom, $urandom);
        step(2'b00, $urandom, $urandom, $urandom);
        checks++;
        if (obs[2][9:0] !== 10'b1000000000) begin
            errors++;
            $display("FAIL video_ff got %b want 1000000000", obs[2][9:0]);
        end
    endtask

    task automatic test_terc4;
        obs.delete();
        for (int i = 0; i < 16; i++) step(2'b10, $urandom, $urandom, {CH{4'(i)}});
        step(2'b00, $urandom, $urandom, $urandom);
        step(2'b00, $urandom, $urandom, $urandom);
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < CH; k++) begin
                checks++;
                if (obs[2+i][10*k +: 10] !== TERC[i]) begin
                    errors++;
                    $display("FAIL terc4 nib=%0d lane=%0d got %b want %b",
                             i, k, obs[2+i][10*k +: 10], TERC[i]);
                end
            end
    endtask

    task automatic test_guard;
        logic [9:0] want [CH];
        want = '{10'b1011001100, 10'b0100110011, 10'b1011001100, 10'b1011001100};
        obs.delete();
        step(2'b11, $urandom, $urandom, $urandom);
        step(2'b00, $urandom, $urandom, $urandom);
        step(2'b00, $urandom, $urandom, $urandom);
        for (int k = 0; k < CH; k++) begin
            checks++;
            if (obs[2][10*k +: 10] !== want[k]) begin
                errors++;
                $display("FAIL guard lane=%0d got %b want %b", k, obs[2][10*k +: 10], want[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] want [3];
        want = '{10'b0100000000, 10'b1101010100, 10'b0100000000};
        step(2'b00, $urandom, '0, $urandom);
        obs.delete();
        step(2'b01, '0, $urandom, $urandom);
        step(2'b00, $urandom, '0, $urandom);
        step(2'b01, '0, $urandom, $urandom);
        step(2'b00, $urandom, $urandom, $urandom);
        step(2'b00, $urandom, $urandom, $urandom);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[2+i][9:0] !== want[i]) begin
                errors++;
                $display("FAIL back_to_back sym=%0d got %b want %b", i, obs[2+i][9:0], want[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (tmds !== {CH{C00}}) begin
            errors++;
            $display("FAIL async_reset_tmds got %h want %h", tmds, {CH{C00}});
        end
        checks++;
        if (mode_out !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_mode got %b want 00", mode_out);
        end
        mode = 2'b00; vd = '0; cd = '0; aux = '0;
        @(negedge pixclk);
        rst_n = 1'b1;
        restart_model();
    endtask

    task automatic test_random;
        logic [1:0] m;
        int r;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) test_async_reset();
            r = $urandom_range(0, 9);
            if (r < 6)      m = 2'b01;
            else if (r < 7) m = 2'b00;
            else if (r < 8) m = 2'b10;
            else            m = 2'b11;
            step(m, $urandom, $urandom, $urandom);
        end
        repeat (2) step(2'b00, $urandom, $urandom, $urandom);
    endtask

    initial begin
        test_reset();
        test_control();
        test_video_zero();
        test_video_ff();
        test_terc4();
        test_guard();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
